// File: rtl/fifo_uart_tx_if.sv
// FIFO-read / serial-line bundle for fifo_uart_tx.
// The transmitter is the read master: it owns the read strobe and the line,
// and the FIFO/environment side owns the data, empty flag and enable.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH:0] fifo_data;
  logic                fifo_empty;
  logic                tx_enable;
  logic                Read_enable;
  logic                tx_serial;
  logic                tx_busy;
  logic                tx_done;

  modport master (
    input  fifo_data, fifo_empty, tx_enable,
    output Read_enable, tx_serial, tx_busy, tx_done
  );

  modport slave (
    output fifo_data, fifo_empty, tx_enable,
    input  Read_enable, tx_serial, tx_busy, tx_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Read-side FIFO drain into a UART-style serial frame:
// start bit, DATA_WIDTH data bits LSB first, optional even parity, one stop bit.
// Every output is a flop; the output comb process computes their next values
// from the next state so the line changes exactly on state boundaries.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic           clk_read,
  input  logic           Reset_n,
  fifo_uart_tx_if.master bus
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic                  parity_q, parity_d;
  logic                  re_q, re_d;
  logic                  ser_q, ser_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  // The FIFO's extra top bit carries nothing for the line.
  logic unused_fifo_msb;
  assign unused_fifo_msb = bus.fifo_data[DATA_WIDTH];

  assign bit_end = (baud_q == BAUD_LAST);

  // State, datapath and output registers; reset drops the frame and idles the line.
  always_ff @(posedge clk_read) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      baud_q    <= '0;
      parity_q  <= 1'b0;
      re_q      <= 1'b0;
      ser_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      baud_q    <= baud_d;
      parity_q  <= parity_d;
      re_q      <= re_d;
      ser_q     <= ser_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state: FIFO flags and enable only matter in IDLE; a started frame always finishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.tx_enable && !bus.fifo_empty) state_d = S_REQ;
      S_REQ:    state_d = S_LOAD;
      S_LOAD:   state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end && (bit_idx_q == IDX_LAST))
          state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath: counters/shifter advance per bit, registered outputs follow state_d.
  always_comb begin
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    baud_d    = baud_q;
    parity_d  = parity_q;
    case (state_q)
      S_LOAD: begin
        // FIFO data_out is valid here, one cycle after the read strobe.
        shreg_d   = bus.fifo_data[DATA_WIDTH-1:0];
        bit_idx_d = '0;
        baud_d    = '0;
        parity_d  = (PARITY_EN != 0) ? ^bus.fifo_data[DATA_WIDTH-1:0] : 1'b0;
      end
      S_START, S_PARITY, S_STOP: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
      end
      S_DATA: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          // Hold on the last index so the counter never wraps inside a frame.
          if (bit_idx_q != IDX_LAST) bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      default: baud_d = '0;
    endcase

    ser_d = 1'b1;
    case (state_d)
      S_START:  ser_d = 1'b0;
      S_DATA:   ser_d = shreg_d[0];
      S_PARITY: ser_d = parity_d;
      default:  ser_d = 1'b1;
    endcase
    re_d   = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
  end

  assign bus.Read_enable = re_q;
  assign bus.tx_serial   = ser_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (no parity / even parity),
// each fed by a small behavioral FIFO whose data_out updates on the read strobe.
module tb_fifo_uart_tx;

  logic clk_read = 1'b0;
  logic Reset_n  = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk_read = ~clk_read;
  always @(posedge clk_read) cyc <= cyc + 1;

  fifo_uart_tx_if #(.DATA_WIDTH(8)) if0 ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) if1 ();

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_tx0 (
    .clk_read(clk_read), .Reset_n(Reset_n), .bus(if0.master));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_tx1 (
    .clk_read(clk_read), .Reset_n(Reset_n), .bus(if1.master));

  // Behavioral FIFOs: written only by the stimulus process, read by the strobe.
  logic [8:0] mem0 [0:63];
  logic [8:0] mem1 [0:63];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
  logic [8:0] dout0 = '0, dout1 = '0;

  always @(posedge clk_read) begin
    if (if0.Read_enable) begin dout0 <= mem0[rp0 % 64]; rp0 <= rp0 + 1; end
    if (if1.Read_enable) begin dout1 <= mem1[rp1 % 64]; rp1 <= rp1 + 1; end
  end

  assign if0.fifo_data  = dout0;
  assign if0.fifo_empty = (wp0 == rp0);
  assign if1.fifo_data  = dout1;
  assign if1.fifo_empty = (wp1 == rp1);

  function automatic logic s_re(input bit p);   return p ? if1.Read_enable : if0.Read_enable; endfunction
  function automatic logic s_ser(input bit p);  return p ? if1.tx_serial   : if0.tx_serial;   endfunction
  function automatic logic s_busy(input bit p); return p ? if1.tx_busy     : if0.tx_busy;     endfunction
  function automatic logic s_done(input bit p); return p ? if1.tx_done     : if0.tx_done;     endfunction

  task automatic push(input bit p, input logic [8:0] w);
    if (p) begin mem1[wp1 % 64] = w; wp1 = wp1 + 1; end
    else   begin mem0[wp0 % 64] = w; wp0 = wp0 + 1; end
  endtask

  // Waits (bounded) for the REQ cycle, then checks every cycle of the frame.
  task automatic check_frame(input bit p, input logic [7:0] d, input logic exp_par,
                             input string nm);
    logic [10:0] eb;
    int nb;
    bit found;
    bit bad;
    logic got;
    nb = p ? 11 : 10;
    eb = '1;
    eb[0] = 1'b0;
    for (int i = 0; i < 8; i++) eb[i+1] = d[i];
    if (p) eb[9] = exp_par;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_read);
      if (s_re(p) === 1'b1) found = 1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL %s req: Read_enable never rose within 200 cycles", nm);
      return;
    end
    @(negedge clk_read);
    tests++;
    if (s_re(p) !== 1'b0 || s_busy(p) !== 1'b1) begin
      fails++;
      $display("FAIL %s load: re=%b busy=%b, want re=0 busy=1", nm, s_re(p), s_busy(p));
    end
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      got = eb[b];
      for (int c = 0; c < 4; c++) begin
        @(negedge clk_read);
        if (s_ser(p) !== eb[b]) begin bad = 1; got = s_ser(p); end
        if (s_done(p) !== ((b == nb - 1) && (c == 3))) bad = 1;
        if (s_re(p) !== 1'b0 || s_busy(p) !== 1'b1) bad = 1;
      end
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL %s bit%0d: serial=%b done=%b re=%b busy=%b, want serial=%b",
                 nm, b, got, s_done(p), s_re(p), s_busy(p), eb[b]);
      end
    end
    @(negedge clk_read);
    tests++;
    if (s_busy(p) !== 1'b0 || s_ser(p) !== 1'b1 || s_done(p) !== 1'b0) begin
      fails++;
      $display("FAIL %s idle: busy=%b serial=%b done=%b, want 0 1 0",
               nm, s_busy(p), s_ser(p), s_done(p));
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    if0.tx_enable = 1'b0;
    if1.tx_enable = 1'b0;
    repeat (3) @(negedge clk_read);
    for (int p = 0; p < 2; p++) begin
      tests++;
      if (s_ser(p[0]) !== 1'b1) begin fails++; $display("FAIL reset serial[%0d]: got %b want 1", p, s_ser(p[0])); end
      tests++;
      if (s_re(p[0]) !== 1'b0) begin fails++; $display("FAIL reset re[%0d]: got %b want 0", p, s_re(p[0])); end
      tests++;
      if (s_busy(p[0]) !== 1'b0) begin fails++; $display("FAIL reset busy[%0d]: got %b want 0", p, s_busy(p[0])); end
      tests++;
      if (s_done(p[0]) !== 1'b0) begin fails++; $display("FAIL reset done[%0d]: got %b want 0", p, s_done(p[0])); end
    end
    Reset_n = 1'b1;
    repeat (2) @(negedge clk_read);
  endtask

  task automatic test_single;
    int n;
    push(0, 9'h0A5);
    if0.tx_enable = 1'b1;
    check_frame(0, 8'hA5, 1'b0, "single_a5");
    n = 0;
    repeat (20) begin
      @(negedge clk_read);
      if (if0.Read_enable === 1'b1) n++;
    end
    tests++;
    if (n != 0 || if0.tx_serial !== 1'b1) begin
      fails++;
      $display("FAIL single_after: extra re=%0d serial=%b, want 0 and 1", n, if0.tx_serial);
    end
  endtask

  task automatic test_parity;
    push(1, 9'h0A5);
    push(1, 9'h007);
    if1.tx_enable = 1'b1;
    check_frame(1, 8'hA5, 1'b0, "parity_a5");
    check_frame(1, 8'h07, 1'b1, "parity_07");
    if1.tx_enable = 1'b0;
    repeat (5) @(negedge clk_read);
  endtask

  task automatic test_back_to_back;
    int re_cyc [0:7];
    int n_re, n_done;
    n_re = 0;
    n_done = 0;
    for (int i = 1; i <= 4; i++) push(0, 9'(i));
    for (int i = 0; i < 250; i++) begin
      @(negedge clk_read);
      if (if0.Read_enable === 1'b1) begin
        if (n_re < 8) re_cyc[n_re] = cyc;
        n_re++;
      end
      if (if0.tx_done === 1'b1) n_done++;
    end
    tests++;
    if (n_re != 4) begin fails++; $display("FAIL b2b re_count: got %0d want 4", n_re); end
    tests++;
    if (n_done != 4) begin fails++; $display("FAIL b2b done_count: got %0d want 4", n_done); end
    for (int i = 1; i < 4 && i < n_re; i++) begin
      tests++;
      if (re_cyc[i] - re_cyc[i-1] != 43) begin
        fails++;
        $display("FAIL b2b gap%0d: got %0d want 43", i, re_cyc[i] - re_cyc[i-1]);
      end
    end
  endtask

  task automatic test_gating;
    int n_re, n_low;
    bit found;
    n_re = 0;
    n_low = 0;
    if0.tx_enable = 1'b1;
    repeat (100) begin
      @(negedge clk_read);
      if (if0.Read_enable !== 1'b0) n_re++;
      if (if0.tx_serial !== 1'b1) n_low++;
    end
    tests++;
    if (n_re != 0 || n_low != 0) begin
      fails++;
      $display("FAIL empty_gate: re=%0d low=%0d, want 0 0", n_re, n_low);
    end
    push(0, 9'h055);
    push(0, 9'h066);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_read);
      if (if0.Read_enable === 1'b1) found = 1;
    end
    repeat (10) @(negedge clk_read);
    if0.tx_enable = 1'b0;
    for (int i = 0; i < 60 && found; i++) begin
      @(negedge clk_read);
      if (if0.tx_done === 1'b1) found = 0;
    end
    tests++;
    if (found) begin fails++; $display("FAIL enable_drop: frame did not complete (tx_done missing)"); end
    n_re = 0;
    n_low = 0;
    repeat (100) begin
      @(negedge clk_read);
      if (if0.Read_enable !== 1'b0) n_re++;
      if (if0.tx_serial !== 1'b1) n_low++;
    end
    tests++;
    if (n_re != 0 || n_low != 0) begin
      fails++;
      $display("FAIL enable_hold: re=%0d low=%0d, want 0 0", n_re, n_low);
    end
    if0.tx_enable = 1'b1;
    check_frame(0, 8'h66, 1'b0, "enable_resume");
  endtask

  task automatic test_reset_mid;
    bit found;
    push(0, 9'h0FF);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_read);
      if (if0.Read_enable === 1'b1) found = 1;
    end
    repeat (19) @(negedge clk_read);
    tests++;
    if (!found || if0.tx_busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre: found=%0d busy=%b, want 1 1", found, if0.tx_busy);
    end
    Reset_n = 1'b0;
    @(negedge clk_read);
    tests++;
    if (if0.tx_serial !== 1'b1 || if0.tx_busy !== 1'b0 || if0.Read_enable !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: serial=%b busy=%b re=%b, want 1 0 0",
               if0.tx_serial, if0.tx_busy, if0.Read_enable);
    end
    Reset_n = 1'b1;
    repeat (2) @(negedge clk_read);
    push(0, 9'h05A);
    check_frame(0, 8'h5A, 1'b0, "rst_after");
  endtask

  task automatic test_msb;
    push(0, 9'h13C);
    check_frame(0, 8'h3C, 1'b0, "msb_ignored");
  endtask

  initial begin
    if0.tx_enable = 1'b0;
    if1.tx_enable = 1'b0;
    test_reset;
    test_single;
    test_parity;
    test_back_to_back;
    test_gating;
    test_reset_mid;
    test_msb;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the FIFO: runs on the FIFO read clock, pops one word at a time through the FIFO's `Read_enable`/`data_out` port, and serializes it onto a UART-style line. The frame is one start bit, DATA_WIDTH data bits sent LSB first, an optional even-parity bit, and one stop bit. It is the stage directly downstream of the FIFO and drains it whenever the line is free and transmission is enabled.

## Interface
Parameters:
- DATA_WIDTH, 8, payload bits per word; must match the FIFO.
- CLKS_PER_BIT, 4, clk_read cycles per serial bit; must be ≥ 2.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.

Ports:
- clk_read  input  1  single clock for the block; all logic is on its rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- fifo_data  input  DATA_WIDTH+1  FIFO data_out. Bits [DATA_WIDTH-1:0] are the payload; bit [DATA_WIDTH] is ignored.
- fifo_empty  input  1  FIFO empty flag; high means nothing to read.
- tx_enable  input  1  permits starting new frames; a frame already in progress always completes.
- Read_enable  output  1  drives the FIFO read strobe; registered; high for exactly one cycle per popped word.
- tx_serial  output  1  serial line; idles high; registered.
- tx_busy  output  1  high from the REQ state through the end of STOP.
- tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- States: IDLE, REQ, LOAD, START, DATA, PARITY, STOP. The state register and all outputs are registered.
- IDLE
  - tx_serial=1, Read_enable=0, tx_busy=0.
  - If tx_enable=1 and fifo_empty=0, go to REQ. Otherwise stay in IDLE.
- REQ
  - Read_enable=1 for this one cycle only. The FIFO latches data_out at the end of this cycle.
  - Always go to LOAD.
- LOAD
  - Read_enable=0.
  - At the end of the cycle, capture fifo_data[DATA_WIDTH-1:0] into the shift register and clear the bit counter.
  - If PARITY_EN=1, compute parity = XOR of the captured bits.
  - Go to START.
- START
  - tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA
  - tx_serial = shreg[0] for CLKS_PER_BIT cycles, then shift right and increment bit_idx.
  - After bit DATA_WIDTH-1, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY
  - tx_serial = parity for CLKS_PER_BIT cycles, then go to STOP.
- STOP
  - tx_serial=1 for CLKS_PER_BIT cycles.
  - tx_done=1 in the last of those cycles.
  - Go to IDLE unconditionally.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1, and wraps to 0 on each bit boundary.
  - bit_idx is $clog2(DATA_WIDTH) bits wide, counts 0..DATA_WIDTH-1, and never wraps mid-frame.
- fifo_empty and tx_enable are sampled only in IDLE. Changes in any other state have no effect.
- The block never issues Read_enable while fifo_empty=1.
- Reset (Reset_n=0 at a rising edge):
  - Next state is IDLE; tx_serial=1, Read_enable=0, tx_busy=0, tx_done=0.
  - Shift register and counters are cleared.
  - If reset lands mid-frame, the frame is aborted and the line returns high on the next cycle.
  - If reset lands in REQ or LOAD, the popped word is discarded. This loss is accepted.

## Timing
- Let k be an IDLE cycle with tx_enable=1 and fifo_empty=0.
- Read_enable is high in cycle k+1 (REQ).
- Data is captured at the end of cycle k+2 (LOAD).
- The start bit occupies cycles k+3 .. k+3+C-1, where C = CLKS_PER_BIT.
- Data bit i occupies cycles k+3+C(1+i) .. k+3+C(2+i)-1.
- Frame length is F = C·(DATA_WIDTH+2+PARITY_EN) cycles. tx_done pulses in cycle k+2+F.
- Back-to-back words: the stop bit is followed by IDLE, REQ and LOAD, giving 3 extra line-high cycles before the next start bit. Frame period is F+3 cycles.
- tx_busy rises in cycle k+1 and falls in the cycle after tx_done.

## Test plan
- Single word, C=4, PARITY_EN=0:
  - Stimulus: FIFO holds 0xA5.
  - Response: one Read_enable pulse; tx_serial sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx_done 40 cycles after the start-bit edge; then IDLE with line high.
- Parity, PARITY_EN=1:
  - Stimulus: send 0xA5, then 0x07.
  - Response: parity bit is 0 for 0xA5 and 1 for 0x07; frame is 44 cycles.
- Back-to-back drain:
  - Stimulus: FIFO holds 0x01, 0x02, 0x03, 0x04 (full, depth 4).
  - Response: 4 frames; Read_enable pulses exactly 4 times, 43 cycles apart; no pulse after fifo_empty=1; tx_done count is 4.
- Empty and enable gating:
  - fifo_empty=1 for 100 cycles → Read_enable stays 0 and tx_serial stays 1.
  - tx_enable dropped mid-frame → current frame completes and no new REQ is issued until tx_enable returns high.
- Reset mid-frame:
  - Stimulus: assert Reset_n=0 during data bit 3 of 0xFF.
  - Response: tx_serial=1, tx_busy=0, Read_enable=0 on the next cycle; after release, the next FIFO word transmits normally.
- Ignored FIFO MSB:
  - Stimulus: fifo_data bit [8]=1 with payload 0x3C.
  - Response: serialized payload is exactly 0x3C.
